// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch path: state encoding,
// word width, PC increment and the word-alignment helper.
package cpu_fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned CTR_W  = 8;

  localparam logic [INST_W-1:0] PC_INC     = 32'd4;
  // Low address bits that must be zero for a word-aligned access.
  localparam logic [INST_W-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DELIVER = 2'd2
  } fetch_state_e;

  function automatic logic is_aligned(input logic [INST_W-1:0] addr);
    return (addr & ALIGN_MASK) == '0;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Load/clear/enable cycle counter with a terminal-count flag. The flag is
// high during the TERMINAL-th enabled cycle after a clear, so the owner can
// act on that same edge. Shared with the data-memory port.
module fetch_timeout_ctr
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned TERMINAL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CTR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(TERMINAL - 1);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  // Next count: clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one req/ack memory read per
// FetchStart and hands the word to the IR with a one-cycle IRWrite strobe.
// Every output comes from a register or from the state register alone.
module inst_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FetchStart,
  input  logic        PCWrite,
  input  logic [31:0] NextPC,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic [31:0] Instruction,
  output logic        IRWrite,
  output logic [31:0] PC,
  output logic        Busy,
  output logic        FetchErr
);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] instr_q, instr_d;
  logic [INST_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [INST_W-1:0] fetch_addr;
  logic              ctr_clear, ctr_en, ctr_tc;

  fetch_timeout_ctr #(
    .TERMINAL (TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .rst        (reset),
    .clear_i    (ctr_clear),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (ctr_en),
    .tc_o       (ctr_tc)
  );

  // Next-state and datapath updates; the counter only runs while in REQ.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    err_d      = 1'b0;
    ctr_clear  = 1'b1;
    ctr_en     = 1'b0;
    // A simultaneous PCWrite redirects the fetch to the new target.
    fetch_addr = PCWrite ? NextPC : pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (PCWrite) begin
          pc_d = NextPC;
        end
        if (FetchStart) begin
          if (!is_aligned(fetch_addr)) begin
            err_d = 1'b1;
          end else begin
            addr_d  = fetch_addr;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        ctr_clear = 1'b0;
        ctr_en    = 1'b1;
        // An ack on the final allowed cycle still completes the fetch.
        if (MemAck) begin
          instr_d = MemRData;
          pc_d    = addr_q + PC_INC;
          state_d = ST_DELIVER;
        end else if (ctr_tc) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset takes effect without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign MemReq      = (state_q == ST_REQ);
  assign IRWrite     = (state_q == ST_DELIVER);
  assign Busy        = (state_q == ST_REQ) || (state_q == ST_DELIVER);
  assign MemAddr     = addr_q;
  assign Instruction = instr_q;
  assign PC          = pc_q;
  assign FetchErr    = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. Completed fetches are pushed to a
// scoreboard when the ack is driven; a negedge monitor pops and compares on
// every IRWrite strobe.
module tb_inst_fetch_unit;

  localparam logic [31:0] PC_RST = 32'h0000_0000;
  localparam int unsigned TMO    = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        FetchStart = 1'b0;
  logic        PCWrite = 1'b0;
  logic [31:0] NextPC = '0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = '0;
  logic [31:0] Instruction;
  logic        IRWrite;
  logic [31:0] PC;
  logic        Busy;
  logic        FetchErr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] exp_pc = PC_RST;
  logic [31:0] exp_instr = '0;

  inst_fetch_unit #(
    .PC_RESET (PC_RST),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .FetchStart  (FetchStart),
    .PCWrite     (PCWrite),
    .NextPC      (NextPC),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemAck      (MemAck),
    .MemRData    (MemRData),
    .Instruction (Instruction),
    .IRWrite     (IRWrite),
    .PC          (PC),
    .Busy        (Busy),
    .FetchErr    (FetchErr)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every IRWrite strobe must match the oldest expected fetch.
  always @(negedge clk) begin
    if (IRWrite === 1'b1) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_irwrite: got Instruction=%h PC=%h, expected no strobe", Instruction, PC);
      end else begin
        e = sb_q.pop_front();
        if (Instruction !== e.instr || PC !== e.pc) begin
          failures++;
          $display("FAIL sb_deliver: got Instruction=%h PC=%h, expected Instruction=%h PC=%h",
                   Instruction, PC, e.instr, e.pc);
        end else begin
          $display("deliver ok: Instruction=%h PC=%h", Instruction, PC);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch; ack is driven on the (delay+1)-th REQ cycle.
  task automatic do_fetch(input bit use_pcw, input logic [31:0] npc, input int delay,
                          input logic [31:0] rdata, input bit poke_deliver);
    logic [31:0] addr;
    addr = use_pcw ? npc : exp_pc;
    checks++;
    if (MemReq !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL fetch_idle_before: got MemReq=%b Busy=%b, expected 0 0", MemReq, Busy);
    end
    PCWrite = use_pcw;
    NextPC = npc;
    FetchStart = 1'b1;
    step();
    PCWrite = 1'b0;
    FetchStart = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      checks++;
      if (MemReq !== 1'b1 || MemAddr !== addr || Busy !== 1'b1 || IRWrite !== 1'b0 || FetchErr !== 1'b0) begin
        failures++;
        $display("FAIL fetch_req_cycle%0d: got MemReq=%b MemAddr=%h Busy=%b IRWrite=%b FetchErr=%b, expected 1 %h 1 0 0",
                 i, MemReq, MemAddr, Busy, IRWrite, FetchErr, addr);
      end
      if (i == delay) begin
        MemAck = 1'b1;
        MemRData = rdata;
        sb_q.push_back('{instr: rdata, pc: addr + 32'd4});
      end
      step();
    end
    MemAck = 1'b0;
    MemRData = 32'hDEAD_BEEF;
    exp_pc = addr + 32'd4;
    exp_instr = rdata;
    checks++;
    if (IRWrite !== 1'b1 || MemReq !== 1'b0 || Busy !== 1'b1 || FetchErr !== 1'b0) begin
      failures++;
      $display("FAIL fetch_deliver: got IRWrite=%b MemReq=%b Busy=%b FetchErr=%b, expected 1 0 1 0",
               IRWrite, MemReq, Busy, FetchErr);
    end
    if (poke_deliver) begin
      FetchStart = 1'b1;
      PCWrite = 1'b1;
      NextPC = 32'h0000_0100;
    end
    step();
    FetchStart = 1'b0;
    PCWrite = 1'b0;
    checks++;
    if (IRWrite !== 1'b0 || Busy !== 1'b0 || MemReq !== 1'b0 || PC !== exp_pc || MemAddr !== addr) begin
      failures++;
      $display("FAIL fetch_after: got IRWrite=%b Busy=%b MemReq=%b PC=%h MemAddr=%h, expected 0 0 0 %h %h",
               IRWrite, Busy, MemReq, PC, MemAddr, exp_pc, addr);
    end
    $display("fetch addr=%h delay=%0d data=%h -> PC=%h", addr, delay, rdata, PC);
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (PC !== PC_RST || Instruction !== 32'h0 || IRWrite !== 1'b0 || MemReq !== 1'b0 ||
        MemAddr !== 32'h0 || Busy !== 1'b0 || FetchErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got PC=%h Instr=%h IRWrite=%b MemReq=%b MemAddr=%h Busy=%b FetchErr=%b, expected all zero",
               PC, Instruction, IRWrite, MemReq, MemAddr, Busy, FetchErr);
    end
    reset = 1'b0;
    step();
    $display("reset released PC=%h", PC);
  endtask

  task automatic test_basic();
    do_fetch(1'b0, 32'h0, 0, 32'h2008_000A, 1'b0);
  endtask

  task automatic test_delayed_ack();
    do_fetch(1'b0, 32'h0, 5, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_pcwrite_fetch();
    do_fetch(1'b1, 32'h0000_0040, 1, 32'h3333_4444, 1'b0);
  endtask

  task automatic test_timeout();
    FetchStart = 1'b1;
    step();
    FetchStart = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      checks++;
      if (MemReq !== 1'b1 || FetchErr !== 1'b0) begin
        failures++;
        $display("FAIL timeout_req_cycle%0d: got MemReq=%b FetchErr=%b, expected 1 0", i, MemReq, FetchErr);
      end
      step();
    end
    checks++;
    if (FetchErr !== 1'b1 || MemReq !== 1'b0 || Busy !== 1'b0 || PC !== exp_pc || Instruction !== exp_instr) begin
      failures++;
      $display("FAIL timeout_abort: got FetchErr=%b MemReq=%b Busy=%b PC=%h Instr=%h, expected 1 0 0 %h %h",
               FetchErr, MemReq, Busy, PC, Instruction, exp_pc, exp_instr);
    end
    step();
    checks++;
    if (FetchErr !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width: got FetchErr=%b, expected 0", FetchErr);
    end
    $display("timeout abort PC=%h", PC);
  endtask

  task automatic test_ack_on_last();
    do_fetch(1'b0, 32'h0, int'(TMO) - 1, 32'h5555_6666, 1'b0);
  endtask

  task automatic test_misaligned();
    PCWrite = 1'b1;
    NextPC = 32'h0000_0042;
    step();
    PCWrite = 1'b0;
    checks++;
    if (PC !== 32'h0000_0042) begin
      failures++;
      $display("FAIL misalign_pcwrite: got PC=%h, expected 00000042", PC);
    end
    FetchStart = 1'b1;
    step();
    FetchStart = 1'b0;
    checks++;
    if (FetchErr !== 1'b1 || MemReq !== 1'b0 || Busy !== 1'b0 || PC !== 32'h0000_0042) begin
      failures++;
      $display("FAIL misalign_err: got FetchErr=%b MemReq=%b Busy=%b PC=%h, expected 1 0 0 00000042",
               FetchErr, MemReq, Busy, PC);
    end
    step();
    checks++;
    if (FetchErr !== 1'b0 || MemReq !== 1'b0) begin
      failures++;
      $display("FAIL misalign_after: got FetchErr=%b MemReq=%b, expected 0 0", FetchErr, MemReq);
    end
    exp_pc = 32'h0000_0042;
    $display("misaligned fetch rejected PC=%h", PC);
  endtask

  task automatic test_wrap();
    do_fetch(1'b1, 32'hFFFF_FFFC, 2, 32'h7777_8888, 1'b0);
    checks++;
    if (PC !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: got PC=%h, expected 00000000", PC);
    end
  endtask

  task automatic test_ignored_inputs();
    logic [31:0] pc_before;
    // Control requests during DELIVER must be dropped.
    do_fetch(1'b0, 32'h0, 0, 32'h9999_AAAA, 1'b1);
    pc_before = exp_pc;
    step();
    checks++;
    if (MemReq !== 1'b0 || Busy !== 1'b0 || PC !== pc_before) begin
      failures++;
      $display("FAIL ignore_deliver: got MemReq=%b Busy=%b PC=%h, expected 0 0 %h", MemReq, Busy, PC, pc_before);
    end
    // A stray ack in IDLE must not load Instruction.
    MemAck = 1'b1;
    MemRData = 32'hBAD0_BAD0;
    step();
    step();
    MemAck = 1'b0;
    checks++;
    if (Instruction !== exp_instr || IRWrite !== 1'b0 || PC !== pc_before) begin
      failures++;
      $display("FAIL ignore_ack_idle: got Instr=%h IRWrite=%b PC=%h, expected %h 0 %h",
               Instruction, IRWrite, PC, exp_instr, pc_before);
    end
    $display("ignored inputs PC=%h", PC);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      do_fetch(1'b0, 32'h0, 0, 32'hC000_0000 + k, 1'b0);
    end
  endtask

  task automatic test_reset_mid_fetch();
    FetchStart = 1'b1;
    step();
    FetchStart = 1'b0;
    checks++;
    if (MemReq !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got MemReq=%b, expected 1", MemReq);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (MemReq !== 1'b0 || Busy !== 1'b0 || IRWrite !== 1'b0 || PC !== PC_RST ||
        Instruction !== 32'h0 || MemAddr !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_async: got MemReq=%b Busy=%b IRWrite=%b PC=%h Instr=%h MemAddr=%h, expected 0 0 0 %h 0 0",
               MemReq, Busy, IRWrite, PC, Instruction, MemAddr, PC_RST);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (MemReq !== 1'b0 || PC !== PC_RST) begin
      failures++;
      $display("FAIL rst_mid_after: got MemReq=%b PC=%h, expected 0 %h", MemReq, PC, PC_RST);
    end
    exp_pc = PC_RST;
    exp_instr = '0;
    $display("reset during REQ PC=%h", PC);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_pcwrite_fetch();
    test_timeout();
    test_ack_on_last();
    test_misaligned();
    test_wrap();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid_fetch();
    step();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d undelivered fetches, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
